// File: rtl/frame_l3_pkg.sv
// Shared types and helpers for the L3 transmit frame arbiter.
// Holds the FSM state enum, the abort byte value and a clog2 helper.
package frame_l3_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      PASS     = 2'd2,
      GAP      = 2'd3
   } state_t;

   localparam logic [7:0] ABORT_DATA = 8'h00;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/frame_l3_rr_pick.sv
// Combinational round-robin picker: scans req_i starting at ptr_i.
// Ports: req_i (requests), ptr_i (first index checked), gnt_o (one-hot
// winner), idx_o (winner index), any_o (some request present).
module frame_l3_rr_pick
   import frame_l3_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int SRCW = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [SRCW-1:0] ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [SRCW-1:0] idx_o,
   output logic            any_o
);

   always_comb begin
      int j;
      logic found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr_i) + k) % NREQ;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = SRCW'(j);
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/frame_l3_tx_arbiter.sv
// Frame-level arbiter sharing the L3 byte path among NREQ sources, with
// round-robin grants, inter-frame gap and stall timeout.
// Ports: Clk/Rst, ReqIn/GntOut (request/one-hot grant), per-source
// SoFIn/EoFIn/ValIn/ErrIn/DataIn, muxed SoFOut/EoFOut/ValOut/ErrOut/
// DataOut (1-cycle latency), SrcOut (granted index), BusyOut (not IDLE).
// Optional macro FRAME_L3_ARB_FIXED_PRIO_EN: source 0 has fixed priority,
// sources 1..NREQ-1 rotate among themselves.
module frame_l3_tx_arbiter
   import frame_l3_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int IFG     = 12,
   parameter int TIMEOUT = 2048,
   parameter int SRCW    = 2
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [NREQ-1:0]   ReqIn,
   output logic [NREQ-1:0]   GntOut,
   input  logic [NREQ-1:0]   SoFIn,
   input  logic [NREQ-1:0]   EoFIn,
   input  logic [NREQ-1:0]   ValIn,
   input  logic [NREQ-1:0]   ErrIn,
   input  logic [8*NREQ-1:0] DataIn,
   output logic              SoFOut,
   output logic              EoFOut,
   output logic              ValOut,
   output logic              ErrOut,
   output logic [7:0]        DataOut,
   output logic [SRCW-1:0]   SrcOut,
   output logic              BusyOut
);

   localparam int TW  = clog2(TIMEOUT + 1);
   localparam int GW0 = clog2(IFG + 1);
   localparam int GW  = (GW0 < 1) ? 1 : GW0;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [SRCW-1:0]   src_q, src_d;
   logic [SRCW-1:0]   ptr_q, ptr_d;
   logic [TW-1:0]     tcnt_q, tcnt_d, tcnt_sat;
   logic [GW-1:0]     gcnt_q, gcnt_d;
   logic              sof_q, sof_d;
   logic              eof_q, eof_d;
   logic              val_q, val_d;
   logic              err_q, err_d;
   logic [7:0]        data_q, data_d;

   logic              g_val, g_sof, g_eof, g_err;
   logic [7:0]        g_data;
   logic              tmo, gap_done;

   logic [NREQ-1:0]   pick_req, pick_gnt;
   logic [SRCW-1:0]   pick_idx, ptr_nxt;
   logic              pick_any;

   // Granted source's framing; src_q tracks the grant.
   assign g_val  = ValIn[src_q];
   assign g_sof  = SoFIn[src_q];
   assign g_eof  = EoFIn[src_q];
   assign g_err  = ErrIn[src_q];
   assign g_data = DataIn[8*src_q +: 8];

   assign tmo      = (int'(tcnt_q) >= TIMEOUT - 1);
   assign gap_done = (int'(gcnt_q) + 1 >= IFG);
   assign tcnt_sat = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;

`ifdef FRAME_L3_ARB_FIXED_PRIO_EN
   // Source 0 bypasses rotation; pointer only ever names 1..NREQ-1.
   assign pick_req = ReqIn[0] ? NREQ'(1) : (ReqIn & ~NREQ'(1));
   assign ptr_nxt  = (pick_idx == '0)            ? ptr_q :
                     (int'(pick_idx) + 1 >= NREQ) ? SRCW'(1) :
                                                    pick_idx + 1'b1;
`else
   assign pick_req = ReqIn;
   assign ptr_nxt  = (int'(pick_idx) + 1 >= NREQ) ? '0 : pick_idx + 1'b1;
`endif

   frame_l3_rr_pick #(
      .NREQ (NREQ),
      .SRCW (SRCW)
   ) u_pick (
      .req_i (pick_req),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         src_q   <= '0;
         ptr_q   <= '0;
         tcnt_q  <= '0;
         gcnt_q  <= '0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         val_q   <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
         tcnt_q  <= tcnt_d;
         gcnt_q  <= gcnt_d;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
         val_q   <= val_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   // Next state and counters.
   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      gcnt_d  = gcnt_q;
      unique case (state_q)
         IDLE: begin
            tcnt_d = '0;
            gcnt_d = '0;
            if (pick_any) state_d = WAIT_SOF;
         end
         WAIT_SOF: begin
            // Valid beats without SoF are dropped and do not reset tcnt.
            if (g_val && g_sof) begin
               tcnt_d  = '0;
               state_d = g_eof ? GAP : PASS;
            end else if (tmo) begin
               tcnt_d  = '0;
               state_d = IDLE;
            end else begin
               tcnt_d  = tcnt_sat;
            end
         end
         PASS: begin
            if (g_val) begin
               tcnt_d = '0;
               if (g_eof || g_sof) state_d = GAP;
            end else if (tmo) begin
               tcnt_d  = '0;
               state_d = GAP;
            end else begin
               tcnt_d  = tcnt_sat;
            end
         end
         default: begin
            if (gap_done) begin
               gcnt_d  = '0;
               state_d = IDLE;
            end else begin
               gcnt_d  = gcnt_q + 1'b1;
            end
         end
      endcase
   end

   // Grant, pointer and registered output beat.
   always_comb begin
      gnt_d  = gnt_q;
      src_d  = src_q;
      ptr_d  = ptr_q;
      sof_d  = 1'b0;
      eof_d  = 1'b0;
      val_d  = 1'b0;
      err_d  = 1'b0;
      data_d = data_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d = pick_gnt;
               src_d = pick_idx;
               ptr_d = ptr_nxt;
            end
         end
         WAIT_SOF: begin
            if (g_val && g_sof) begin
               val_d  = 1'b1;
               sof_d  = 1'b1;
               eof_d  = g_eof;
               err_d  = g_err;
               data_d = g_data;
               if (g_eof) gnt_d = '0;
            end else if (tmo) begin
               gnt_d = '0;
            end
         end
         PASS: begin
            if (g_val) begin
               // A repeated SoF closes the frame as an errored EoF.
               val_d  = 1'b1;
               eof_d  = g_eof | g_sof;
               err_d  = g_err | g_sof;
               data_d = g_data;
               if (g_eof || g_sof) gnt_d = '0;
            end else if (tmo) begin
               val_d  = 1'b1;
               eof_d  = 1'b1;
               err_d  = 1'b1;
               data_d = ABORT_DATA;
               gnt_d  = '0;
            end
         end
         default: ;
      endcase
   end

   assign GntOut  = gnt_q;
   assign SrcOut  = src_q;
   assign SoFOut  = sof_q;
   assign EoFOut  = eof_q;
   assign ValOut  = val_q;
   assign ErrOut  = err_q;
   assign DataOut = data_q;
   assign BusyOut = (state_q != IDLE);

endmodule
